// File: rtl/gps_corr_pkg.sv
// Shared definitions for the correlator arms: sign-magnitude field widths,
// default datapath widths and the integrate-and-dump FSM encoding.
package gps_corr_pkg;

  localparam int SM_W      = 5;   // mixer product: sign + magnitude
  localparam int MAG_W     = 4;   // magnitude field of the product
  localparam int ACC_W_DEF = 16;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_ACCUM = 2'd2
  } acc_state_e;

endpackage

// File: rtl/accum_dump_sm2tc.sv
// Combinational sign-magnitude to two's complement converter; negative zero
// naturally maps to 0 because -0 == 0 in two's complement.
module sm2tc
  import gps_corr_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [SM_W-1:0]  i_sm,
  output logic [ACC_W-1:0] o_tc
);

  logic [ACC_W-1:0] w_mag_ext;

  assign w_mag_ext = {{(ACC_W-MAG_W){1'b0}}, i_sm[MAG_W-1:0]};
  assign o_tc      = i_sm[SM_W-1] ? -w_mag_ext : w_mag_ext;

endmodule

// File: rtl/accum_dump.sv
// Integrate-and-dump stage: accumulates converted mixer samples over one code
// epoch and hands the saturated sum, count and flags over a valid/ack handshake.
module accum_dump
  import gps_corr_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [SM_W-1:0]  x_in,
  input  logic             x_en,
  input  logic             dump,
  input  logic             dump_ack,
  output logic             dump_valid,
  output logic [ACC_W-1:0] dump_data,
  output logic [CNT_W-1:0] dump_cnt,
  output logic             dump_sat,
  output logic             overrun
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  acc_state_e       r_state, w_state_next;
  logic [ACC_W-1:0] r_acc, w_value, w_sat_sum, w_acc_next;
  logic [ACC_W:0]   w_sum_ext;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_sat, w_ovf, w_clamp, w_dump_load;
  logic             r_dump_valid, r_dump_sat, r_overrun;
  logic [ACC_W-1:0] r_dump_data;
  logic [CNT_W-1:0] r_dump_cnt;

  sm2tc #(.ACC_W(ACC_W)) u_sm2tc (
    .i_sm (x_in),
    .o_tc (w_value)
  );

  // One guard bit exposes overflow: the two top bits disagree only on wrap.
  assign w_sum_ext  = {r_acc[ACC_W-1], r_acc} + {w_value[ACC_W-1], w_value};
  assign w_ovf      = w_sum_ext[ACC_W] ^ w_sum_ext[ACC_W-1];
  assign w_sat_sum  = !w_ovf ? w_sum_ext[ACC_W-1:0] :
                      (w_sum_ext[ACC_W] ? ACC_MIN : ACC_MAX);
  assign w_clamp    = x_en & w_ovf;
  assign w_acc_next = x_en ? w_sat_sum : r_acc;
  assign w_cnt_next = (x_en && r_cnt != CNT_MAX) ? r_cnt + CNT_W'(1) : r_cnt;

  assign w_dump_load = run && dump && (r_state == ST_ACCUM);

  // NOTE: every output of a combinational block is assigned a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    if (!run) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_next = ST_SYNC;
        ST_SYNC:  if (dump) w_state_next = ST_ACCUM;
        ST_ACCUM: w_state_next = ST_ACCUM;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state      <= ST_IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_sat        <= 1'b0;
      r_dump_valid <= 1'b0;
      r_dump_data  <= '0;
      r_dump_cnt   <= '0;
      r_dump_sat   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state <= w_state_next;

      // Outside ACCUM the epoch state is held at 0; a dump restarts the epoch.
      if (!run || r_state != ST_ACCUM || dump) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
        r_sat <= r_sat | w_clamp;
      end

      if (w_dump_load) begin
        r_dump_valid <= 1'b1;
        r_dump_data  <= w_acc_next;
        r_dump_cnt   <= w_cnt_next;
        r_dump_sat   <= r_sat | w_clamp;
        if (r_dump_valid && !dump_ack) begin
          r_overrun <= 1'b1;
        end else if (r_dump_valid) begin
          r_overrun <= 1'b0;
        end
      end else if (r_dump_valid && dump_ack) begin
        r_dump_valid <= 1'b0;
        r_overrun    <= 1'b0;
      end
    end
  end

  assign dump_valid = r_dump_valid;
  assign dump_data  = r_dump_data;
  assign dump_cnt   = r_dump_cnt;
  assign dump_sat   = r_dump_sat;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_accum_dump.sv
// Directed bench for accum_dump built with ACC_W=8 so saturation is reachable
// with short epochs; expected results are hand-computed constants.
module tb_accum_dump;

  localparam int ACC_W = 8;
  localparam int CNT_W = 16;

  logic             clk, clr, run, x_en, dump, dump_ack;
  logic [4:0]       x_in;
  logic             dump_valid, dump_sat, overrun;
  logic [ACC_W-1:0] dump_data;
  logic [CNT_W-1:0] dump_cnt;

  int n_vec = 0;
  int n_err = 0;

  accum_dump #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .clr        (clr),
    .run        (run),
    .x_in       (x_in),
    .x_en       (x_en),
    .dump       (dump),
    .dump_ack   (dump_ack),
    .dump_valid (dump_valid),
    .dump_data  (dump_data),
    .dump_cnt   (dump_cnt),
    .dump_sat   (dump_sat),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, return at edge + 1.
  task automatic apply(input logic en, input logic [4:0] x, input logic d,
                       input logic ack);
    x_en = en; x_in = x; dump = d; dump_ack = ack;
    @(posedge clk);
    #1;
    x_en = 1'b0; x_in = 5'd0; dump = 1'b0; dump_ack = 1'b0;
  endtask

  task automatic samples(input int n, input logic [4:0] x);
    for (int i = 0; i < n; i++) apply(1'b1, x, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    clr = 1'b0; run = 1'b0; x_en = 1'b0; x_in = 5'd0; dump = 1'b0; dump_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({dump_valid, dump_data, dump_cnt, dump_sat, overrun} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%0d c=%0d s=%b o=%b, want all 0",
               dump_valid, $signed(dump_data), dump_cnt, dump_sat, overrun);
    end
    clr = 1'b1;
  endtask

  task automatic test_align;
    run = 1'b1;
    apply(1'b0, 5'd0, 1'b0, 1'b0);        // IDLE -> SYNC
    samples(5, 5'b00011);                 // ignored in SYNC
    apply(1'b0, 5'd0, 1'b1, 1'b0);        // aligning dump -> ACCUM
    n_vec++;
    if (dump_valid !== 1'b0) begin
      n_err++;
      $display("FAIL align_sync_dump: got v=%b, want v=0", dump_valid);
    end
    samples(9, 5'b00011);
    n_vec++;
    if (dump_valid !== 1'b0) begin
      n_err++;
      $display("FAIL align_premature: got v=%b, want v=0", dump_valid);
    end
    apply(1'b1, 5'b00011, 1'b1, 1'b0);    // 10th sample with dump
    n_vec++;
    if ({dump_valid, dump_data, dump_cnt, dump_sat, overrun} !== {1'b1, 8'd30, 16'd10, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL align_result: got v=%b d=%0d c=%0d s=%b o=%b, want v=1 d=30 c=10 s=0 o=0",
               dump_valid, $signed(dump_data), dump_cnt, dump_sat, overrun);
    end
    apply(1'b0, 5'd0, 1'b0, 1'b1);
    n_vec++;
    if ({dump_valid, dump_data} !== {1'b0, 8'd30}) begin
      n_err++;
      $display("FAIL align_ack: got v=%b d=%0d, want v=0 d=30 (held)",
               dump_valid, $signed(dump_data));
    end
  endtask

  task automatic test_sign;
    samples(1, 5'b10000);
    samples(1, 5'b10110);
    samples(1, 5'b01001);
    samples(1, 5'b10001);
    apply(1'b0, 5'd0, 1'b1, 1'b0);
    n_vec++;
    if ({dump_valid, dump_data, dump_cnt, dump_sat} !== {1'b1, 8'd2, 16'd4, 1'b0}) begin
      n_err++;
      $display("FAIL sign_result: got v=%b d=%0d c=%0d s=%b, want v=1 d=2 c=4 s=0",
               dump_valid, $signed(dump_data), dump_cnt, dump_sat);
    end
    apply(1'b0, 5'd0, 1'b0, 1'b1);
  endtask

  task automatic test_saturation;
    samples(20, 5'b01001);
    apply(1'b0, 5'd0, 1'b1, 1'b0);
    n_vec++;
    if ({dump_valid, dump_data, dump_cnt, dump_sat} !== {1'b1, 8'd127, 16'd20, 1'b1}) begin
      n_err++;
      $display("FAIL sat_pos: got v=%b d=%0d c=%0d s=%b, want v=1 d=127 c=20 s=1",
               dump_valid, $signed(dump_data), dump_cnt, dump_sat);
    end
    apply(1'b0, 5'd0, 1'b0, 1'b1);
    samples(20, 5'b11001);
    apply(1'b0, 5'd0, 1'b1, 1'b0);
    n_vec++;
    if ({dump_valid, dump_data, dump_cnt, dump_sat} !== {1'b1, 8'h80, 16'd20, 1'b1}) begin
      n_err++;
      $display("FAIL sat_neg: got v=%b d=%0d c=%0d s=%b, want v=1 d=-128 c=20 s=1",
               dump_valid, $signed(dump_data), dump_cnt, dump_sat);
    end
    apply(1'b0, 5'd0, 1'b0, 1'b1);
    samples(2, 5'b00001);
    apply(1'b0, 5'd0, 1'b1, 1'b0);
    n_vec++;
    if ({dump_valid, dump_data, dump_cnt, dump_sat} !== {1'b1, 8'd2, 16'd2, 1'b0}) begin
      n_err++;
      $display("FAIL sat_clears: got v=%b d=%0d c=%0d s=%b, want v=1 d=2 c=2 s=0",
               dump_valid, $signed(dump_data), dump_cnt, dump_sat);
    end
    apply(1'b0, 5'd0, 1'b0, 1'b1);
  endtask

  task automatic test_overrun;
    samples(1, 5'b00111);
    apply(1'b0, 5'd0, 1'b1, 1'b0);        // epoch A = 7, left unacked
    n_vec++;
    if ({dump_valid, dump_data, overrun} !== {1'b1, 8'd7, 1'b0}) begin
      n_err++;
      $display("FAIL ovr_epoch_a: got v=%b d=%0d o=%b, want v=1 d=7 o=0",
               dump_valid, $signed(dump_data), overrun);
    end
    samples(1, 5'b10100);
    apply(1'b0, 5'd0, 1'b1, 1'b0);        // epoch B = -4 overwrites A
    n_vec++;
    if ({dump_valid, dump_data, dump_cnt, overrun} !== {1'b1, 8'hFC, 16'd1, 1'b1}) begin
      n_err++;
      $display("FAIL ovr_epoch_b: got v=%b d=%0d c=%0d o=%b, want v=1 d=-4 c=1 o=1",
               dump_valid, $signed(dump_data), dump_cnt, overrun);
    end
    apply(1'b0, 5'd0, 1'b0, 1'b1);
    n_vec++;
    if ({dump_valid, dump_data, overrun} !== {1'b0, 8'hFC, 1'b0}) begin
      n_err++;
      $display("FAIL ovr_ack_clears: got v=%b d=%0d o=%b, want v=0 d=-4 o=0",
               dump_valid, $signed(dump_data), overrun);
    end
    samples(1, 5'b00101);
    apply(1'b0, 5'd0, 1'b1, 1'b0);        // epoch C = 5
    samples(1, 5'b00001);
    apply(1'b0, 5'd0, 1'b1, 1'b1);        // epoch D = 1 with coincident ack
    n_vec++;
    if ({dump_valid, dump_data, overrun} !== {1'b1, 8'd1, 1'b0}) begin
      n_err++;
      $display("FAIL ack_with_dump: got v=%b d=%0d o=%b, want v=1 d=1 o=0",
               dump_valid, $signed(dump_data), overrun);
    end
    apply(1'b0, 5'd0, 1'b0, 1'b1);
    apply(1'b0, 5'd0, 1'b0, 1'b1);        // ack with nothing valid: ignored
    n_vec++;
    if ({dump_valid, dump_data, overrun} !== {1'b0, 8'd1, 1'b0}) begin
      n_err++;
      $display("FAIL idle_ack: got v=%b d=%0d o=%b, want v=0 d=1 o=0",
               dump_valid, $signed(dump_data), overrun);
    end
  endtask

  task automatic test_run_deassert;
    samples(6, 5'b00001);
    run = 1'b0;
    apply(1'b0, 5'd0, 1'b1, 1'b0);        // dump with run low: discarded
    apply(1'b0, 5'd0, 1'b1, 1'b0);        // dump in IDLE: ignored
    n_vec++;
    if (dump_valid !== 1'b0) begin
      n_err++;
      $display("FAIL run_low_no_dump: got v=%b, want v=0", dump_valid);
    end
    run = 1'b1;
    apply(1'b0, 5'd0, 1'b0, 1'b0);        // IDLE -> SYNC
    apply(1'b0, 5'd0, 1'b1, 1'b0);        // aligning dump
    n_vec++;
    if (dump_valid !== 1'b0) begin
      n_err++;
      $display("FAIL run_sync_dump: got v=%b, want v=0", dump_valid);
    end
    samples(3, 5'b00010);
    apply(1'b0, 5'd0, 1'b1, 1'b0);
    n_vec++;
    if ({dump_valid, dump_data, dump_cnt} !== {1'b1, 8'd6, 16'd3}) begin
      n_err++;
      $display("FAIL run_restart: got v=%b d=%0d c=%0d, want v=1 d=6 c=3",
               dump_valid, $signed(dump_data), dump_cnt);
    end
    apply(1'b0, 5'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_epoch;
    samples(2, 5'b00001);
    apply(1'b0, 5'd0, 1'b1, 1'b0);
    samples(1, 5'b10100);
    apply(1'b0, 5'd0, 1'b1, 1'b0);        // unacked overwrite sets overrun
    n_vec++;
    if ({dump_valid, overrun} !== 2'b11) begin
      n_err++;
      $display("FAIL pre_reset_state: got v=%b o=%b, want v=1 o=1", dump_valid, overrun);
    end
    samples(3, 5'b00011);
    #2 clr = 1'b0;                        // between edges: must act at once
    #1;
    n_vec++;
    if ({dump_valid, dump_data, dump_cnt, dump_sat, overrun} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got v=%b d=%0d c=%0d s=%b o=%b, want all 0",
               dump_valid, $signed(dump_data), dump_cnt, dump_sat, overrun);
    end
    clr = 1'b1;
    apply(1'b0, 5'd0, 1'b0, 1'b0);        // IDLE -> SYNC
    samples(2, 5'b00011);
    apply(1'b0, 5'd0, 1'b1, 1'b0);        // must be the aligning dump
    n_vec++;
    if (dump_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_needs_sync: got v=%b, want v=0", dump_valid);
    end
    samples(2, 5'b00011);
    apply(1'b0, 5'd0, 1'b1, 1'b0);
    n_vec++;
    if ({dump_valid, dump_data, dump_cnt, overrun} !== {1'b1, 8'd6, 16'd2, 1'b0}) begin
      n_err++;
      $display("FAIL reset_next_epoch: got v=%b d=%0d c=%0d o=%b, want v=1 d=6 c=2 o=0",
               dump_valid, $signed(dump_data), dump_cnt, overrun);
    end
  endtask

  initial begin
    test_reset;
    test_align;
    test_sign;
    test_saturation;
    test_overrun;
    test_run_deassert;
    test_reset_mid_epoch;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/accum_dump.md
Name: accum_dump

Overview:
- Integrate-and-dump stage directly downstream of the sign-magnitude mixer.
- Takes the mixer's 5-bit sign-magnitude product and converts each sample to two's complement.
- Accumulates the samples over one code epoch, framed by the code generator's dump strobe.
- Presents the epoch sum, sample count and status flags to the tracking processor through a valid/ack handshake.

Parameters:
- ACC_W, 16, accumulator and dump_data width (two's complement, saturating)
- CNT_W, 16, sample counter width (saturating)

Ports:
- clk  input  1  system clock; all logic on the rising edge
- clr  input  1  reset; asynchronous, active-low
- run  input  1  channel enable; 0 forces IDLE
- x_in  input  5  mixer product in sign-magnitude: bit4 = sign (1 = negative), bits3:0 = magnitude
- x_en  input  1  x_in is a valid sample this cycle
- dump  input  1  epoch boundary strobe, one cycle wide
- dump_ack  input  1  processor has consumed dump_data
- dump_valid  output  1  epoch result available
- dump_data  output  ACC_W  signed epoch sum
- dump_cnt  output  CNT_W  number of x_en samples in the epoch
- dump_sat  output  1  accumulator saturated during the epoch
- overrun  output  1  a result was overwritten before it was acked (sticky)

Behaviour:
- Reset (clr=0, asynchronous): FSM goes to IDLE. The accumulator, the counter, the epoch sat flag and every output clear to 0.
- Sign-magnitude conversion: value = sign ? -mag : +mag. Negative zero (5'b10000) maps to 0. All magnitudes 0..15 are accepted.
- The converted value is sign-extended to ACC_W.
- FSM states:
  - IDLE: accumulator and counter are held at 0. run=1 moves to SYNC.
  - SYNC: samples are ignored. The first dump clears the accumulator and counter, then moves to ACCUM. This makes the first epoch aligned.
  - ACCUM: on each cycle with x_en=1, acc += value and cnt += 1.
  - From any state, run=0 returns to IDLE on the next edge. A partial epoch is discarded and no dump is issued.
- Saturation:
  - The sum clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1).
  - Any clamp sets the epoch sat flag, which clears at each dump.
  - cnt stops at 2^CNT_W-1.
- Dump in ACCUM:
  - If x_en=1 in the same cycle as dump, that sample belongs to the ending epoch.
  - dump_data = acc + value (saturated), dump_cnt = cnt + 1, dump_sat = the epoch sat flag OR'd with any clamp from this final sample.
  - The accumulator, counter and sat flag restart from 0 on the next edge; the following sample starts the new epoch.
- Latency and handshake:
  - dump_valid rises on the edge after dump (1 cycle). dump_data, dump_cnt and dump_sat update on that same edge.
  - Outputs are held stable while dump_valid=1.
  - dump_ack=1 while dump_valid=1 clears dump_valid on the next edge. dump_ack while dump_valid=0 is ignored.
- Overrun:
  - A dump while dump_valid=1 and dump_ack=0 overwrites the outputs with the new epoch, keeps dump_valid=1, and sets overrun.
  - dump_ack and dump in the same cycle: the new result loads, dump_valid stays 1, overrun is not set.
  - overrun clears only on an accepted dump_ack (dump_valid=1) or on reset.
- dump in IDLE is ignored.
- Reset asserted mid-epoch discards all state immediately.

Decomposition:
- Shared package (gps_corr_pkg):
  - sign-magnitude field widths (product 5, magnitude 4)
  - default ACC_W/CNT_W
  - FSM state encoding: IDLE=2'd0, SYNC=2'd1, ACCUM=2'd2
- One natural sub-module: sm2tc. It is a combinational 5-bit sign-magnitude to ACC_W two's complement converter, reusable by the Q-arm and other correlator arms.
- The saturating adder stays inline.

Test Plan:
- Reset: clr=0 mid-ACCUM with dump_valid=1 -> all outputs 0 asynchronously, FSM in IDLE, the next epoch needs a SYNC dump.
- Alignment and latency: run=1, 5 samples of +3 before the first dump, then dump, then 10 samples of 5'b00011 with dump on the 10th -> one cycle later dump_valid=1, dump_data=30, dump_cnt=10, dump_sat=0.
- Sign handling: samples 5'b10000, 5'b10110, 5'b01001, 5'b10001 then dump -> dump_data=2 (0-6+9-1), dump_cnt=4.
- Saturation (ACC_W=8): 20 samples of +9 -> dump_data=127, dump_sat=1. Next epoch of 20 samples of -9 -> dump_data=-128, dump_sat=1. An epoch of 2 samples of +1 afterwards -> dump_sat=0.
- Handshake and overrun:
  - Epoch A (sum 7) unacked, then epoch B (sum -4) dumps -> dump_data=-4, overrun=1; ack -> dump_valid=0, overrun=0.
  - ack coincident with the next dump -> dump_valid stays 1, overrun=0.
- run deassert: run=0 mid-epoch after 6 samples -> no dump_valid. run=1 plus two dumps with 3 samples of +2 between them -> dump_data=6, dump_cnt=3.
